output_port_buffer: RTL and testbench

// - Per-output-port buffer between the router crossbar and one outbound link; one instance per output port (4 per router).
// - Accepts whole packets from the crossbar (pkt_out[k] / pkt_out_avail[k]) and drives ob_ready_to_recv[k] back to it.
// - Serialises each 32-bit pkt_t onto the 8-bit link to the neighbouring router/node using the put/free link handshake.

---
 rtl/router_pkg.sv | 27 ++
 rtl/pkt_fifo.sv | 82 ++++++++
 rtl/output_port_buffer.sv | 118 +++++++++++
 tb/tb_output_port_buffer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router types: packet format, serialiser byte count and output FSM states.
// Latency: n/a (types and helper only).
// Backpressure: n/a.
package router_pkg;

    // A 32-bit packet. The first byte on the link is {src, dest}.
    typedef struct packed {
        logic [3:0]  src;
        logic [3:0]  dest;
        logic [23:0] data;
    } pkt_t;

    localparam int PKT_BYTES = 4;

    typedef enum logic {
        IDLE,
        SEND
    } obuf_state_t;

    // Byte idx of a packet, most significant byte first (idx 0 = {src,dest}).
    function automatic logic [7:0] pkt_byte(input pkt_t p, input logic [1:0] idx);
        logic [31:0] pw;
        pw = p;
        return pw[(31 - 8 * int'(idx)) -: 8];
    endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Generic pkt_t FIFO with power-of-2 depth; head is a combinational read of the oldest entry.
// Latency: a packet pushed at one edge is visible on head_o after that edge.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together keeps count.
//
// Ports:
//   clock, reset_n          single clock, synchronous active-low reset
//   push_i / push_dat_i     write a packet at the tail
//   pop_i                   drop the head entry
//   head_o                  oldest stored packet (valid when !empty_o)
//   count_o, full_o, empty_o occupancy
module pkt_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  pkt_t                       push_dat_i,
    input  logic                       pop_i,
    output pkt_t                       head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    pkt_t            mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of 2, so pointer overflow is the wrap DEPTH-1 -> 0.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/output_port_buffer.sv
// Per-output-port buffer: queues crossbar packets and serialises each onto an 8-bit put/free link.
// Latency: push at edge t -> byte0 on the link after edge t+1; 4 bytes on consecutive cycles.
// Backpressure: ready_to_recv drops when full; free_outbound is checked only at packet start.
//
// Ports:
//   clock, reset_n     single clock, synchronous active-low reset
//   pkt_in_avail       crossbar offers pkt_in this cycle
//   pkt_in             packet from the crossbar
//   ready_to_recv      buffer has room (from registered count only)
//   free_outbound      neighbour can take a new packet
//   put_outbound       payload_outbound carries a valid byte (registered)
//   payload_outbound   serialised byte, MSB first (registered)
module output_port_buffer
    import router_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pkt_in_avail,
    input  pkt_t       pkt_in,
    output logic       ready_to_recv,
    input  logic       free_outbound,
    output logic       put_outbound,
    output logic [7:0] payload_outbound
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [1:0]    LAST_BYTE = 2'(PKT_BYTES - 1);

    pkt_t          fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;

    obuf_state_t   state_q;
    logic [1:0]    byte_cnt_q;
    logic [1:0]    byte_cnt_d;
    pkt_t          shift_q;
    logic          put_q;
    logic [7:0]    payload_q;

    // Count only changes on an edge, so a same-cycle pop never reopens a full buffer.
    assign ready_to_recv = (fifo_count != FULL_CNT);
    assign fifo_push     = pkt_in_avail && !fifo_full;

    // A new packet may start from IDLE, or directly after the last byte of the
    // current one so back-to-back packets leave with no idle cycle.
    assign fifo_pop = !fifo_empty && free_outbound &&
                      ((state_q == IDLE) || (byte_cnt_q == LAST_BYTE));

    assign byte_cnt_d = byte_cnt_q + 2'd1;

    pkt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push_i     (fifo_push),
        .push_dat_i (pkt_in),
        .pop_i      (fifo_pop),
        .head_o     (fifo_head),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // byte_cnt_q names the byte currently presented on payload_outbound.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            byte_cnt_q <= 2'd0;
            shift_q    <= '0;
            put_q      <= 1'b0;
            payload_q  <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fifo_pop) begin
                        shift_q    <= fifo_head;
                        byte_cnt_q <= 2'd0;
                        put_q      <= 1'b1;
                        payload_q  <= pkt_byte(fifo_head, 2'd0);
                        state_q    <= SEND;
                    end else begin
                        put_q      <= 1'b0;
                        payload_q  <= 8'h00;
                    end
                end
                SEND: begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        if (fifo_pop) begin
                            shift_q    <= fifo_head;
                            byte_cnt_q <= 2'd0;
                            put_q      <= 1'b1;
                            payload_q  <= pkt_byte(fifo_head, 2'd0);
                        end else begin
                            put_q      <= 1'b0;
                            payload_q  <= 8'h00;
                            state_q    <= IDLE;
                        end
                    end else begin
                        byte_cnt_q <= byte_cnt_d;
                        put_q      <= 1'b1;
                        payload_q  <= pkt_byte(shift_q, byte_cnt_d);
                    end
                end
            endcase
        end
    end

    assign put_outbound     = put_q;
    assign payload_outbound = payload_q;

endmodule

// File: tb/tb_output_port_buffer.sv
// Directed bench for output_port_buffer: reset, latency, fill, drain, free gating,
// simultaneous push/pop with pointer wrap, and reset mid-packet.
module tb_output_port_buffer;
    import router_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       pkt_in_avail;
    pkt_t       pkt_in;
    logic       ready_to_recv;
    logic       free_outbound;
    logic       put_outbound;
    logic [7:0] payload_outbound;

    always #5 clock = ~clock;

    output_port_buffer #(.DEPTH(4)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .pkt_in_avail     (pkt_in_avail),
        .pkt_in           (pkt_in),
        .ready_to_recv    (ready_to_recv),
        .free_outbound    (free_outbound),
        .put_outbound     (put_outbound),
        .payload_outbound (payload_outbound)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] expq [$];
    logic [31:0] acc;
    logic [31:0] fill_pkts [4];
    int          bi    = 0;
    int          nrecv = 0;
    int          nsent = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; values read afterwards are settled post-edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] mk(input int n);
        logic [7:0] b;
        b = 8'(n);
        return {b, 8'hC0 ^ b, 8'h5A, b + 8'h80};
    endfunction

    // Reassemble link bytes into packets and compare with arrival order.
    task automatic mon();
        logic [31:0] e;
        if (put_outbound) begin
            acc = {acc[23:0], payload_outbound};
            bi++;
            if (bi == 4) begin
                e = (expq.size() != 0) ? expq.pop_front() : 32'hFFFF_FFFF;
                chk("wrap_pkt", acc, e);
                nrecv++;
                bi = 0;
            end
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        pkt_in_avail  = 1'b0;
        pkt_in        = '0;
        free_outbound = 1'b0;
        acc           = '0;
        fill_pkts[0]  = 32'h1200_0001;
        fill_pkts[1]  = 32'h2300_0002;
        fill_pkts[2]  = 32'h3400_0003;
        fill_pkts[3]  = 32'h4500_0004;

        // Reset state
        step();
        step();
        chk("rst_put",   32'(put_outbound),        32'h0);
        chk("rst_pay",   32'(payload_outbound),    32'h00);
        chk("rst_ready", 32'(ready_to_recv),       32'h1);
        chk("rst_count", 32'(dut.u_fifo.count_o),  32'h0);
        reset_n = 1'b1;

        // Single packet latency and byte order
        free_outbound = 1'b1;
        pkt_in_avail  = 1'b1;
        pkt_in        = 32'h13AB_CDEF;
        step();
        pkt_in_avail  = 1'b0;
        chk("lat_put_t0", 32'(put_outbound), 32'h0);
        step(); chk("lat_b0", {23'd0, put_outbound, payload_outbound}, 32'h113);
        step(); chk("lat_b1", {23'd0, put_outbound, payload_outbound}, 32'h1AB);
        step(); chk("lat_b2", {23'd0, put_outbound, payload_outbound}, 32'h1CD);
        step(); chk("lat_b3", {23'd0, put_outbound, payload_outbound}, 32'h1EF);
        step(); chk("lat_end", {23'd0, put_outbound, payload_outbound}, 32'h000);

        // Fill with the link held off
        free_outbound = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pkt_in_avail = 1'b1;
            pkt_in       = fill_pkts[i];
            step();
            chk("fill_ready", 32'(ready_to_recv), (i < 3) ? 32'h1 : 32'h0);
        end
        pkt_in       = 32'hDEAD_BEEF;
        step();
        pkt_in_avail = 1'b0;
        chk("full_ready", 32'(ready_to_recv),      32'h0);
        chk("full_count", 32'(dut.u_fifo.count_o), 32'h4);
        chk("full_put",   32'(put_outbound),       32'h0);

        // Back-to-back drain
        free_outbound = 1'b1;
        step();
        chk("drain_ready", 32'(ready_to_recv), 32'h1);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step();
            chk("drain_put", 32'(put_outbound), 32'h1);
            chk("drain_byte", 32'(payload_outbound),
                32'(pkt_byte(pkt_t'(fill_pkts[i / 4]), 2'(i % 4))));
        end
        step();
        chk("drain_end", {23'd0, put_outbound, payload_outbound}, 32'h000);

        // free_outbound drops after byte0: packet completes, next one waits
        pkt_in_avail = 1'b1;
        pkt_in       = 32'h2111_1111;
        step();
        pkt_in       = 32'h3422_2222;
        step();
        chk("fr_a0", {23'd0, put_outbound, payload_outbound}, 32'h121);
        pkt_in_avail  = 1'b0;
        free_outbound = 1'b0;
        step(); chk("fr_a1", {23'd0, put_outbound, payload_outbound}, 32'h111);
        step(); chk("fr_a2", {23'd0, put_outbound, payload_outbound}, 32'h111);
        step(); chk("fr_a3", {23'd0, put_outbound, payload_outbound}, 32'h111);
        step(); chk("fr_wait0", 32'(put_outbound), 32'h0);
        step(); chk("fr_wait1", 32'(put_outbound), 32'h0);
        free_outbound = 1'b1;
        step(); chk("fr_b0", {23'd0, put_outbound, payload_outbound}, 32'h134);
        step(); chk("fr_b1", {23'd0, put_outbound, payload_outbound}, 32'h122);
        step(); chk("fr_b2", {23'd0, put_outbound, payload_outbound}, 32'h122);
        step(); chk("fr_b3", {23'd0, put_outbound, payload_outbound}, 32'h122);
        step(); chk("fr_end", 32'(put_outbound), 32'h0);

        // Simultaneous push and pop at count=2, then a 10-packet stream over the wrap
        free_outbound = 1'b0;
        pkt_in_avail  = 1'b1;
        pkt_in        = mk(1);
        step();
        pkt_in        = mk(2);
        step();
        chk("sim_count_pre", 32'(dut.u_fifo.count_o), 32'h2);
        pkt_in        = mk(3);
        free_outbound = 1'b1;
        step();
        pkt_in_avail  = 1'b0;
        chk("sim_count", 32'(dut.u_fifo.count_o), 32'h2);
        expq.push_back(mk(1));
        expq.push_back(mk(2));
        expq.push_back(mk(3));
        mon();
        for (int cyc = 0; cyc < 300 && nrecv < 13; cyc++) begin
            if (nsent < 10 && ready_to_recv) begin
                pkt_in_avail = 1'b1;
                pkt_in       = mk(nsent + 16);
                expq.push_back(mk(nsent + 16));
                nsent++;
            end else begin
                pkt_in_avail = 1'b0;
            end
            step();
            mon();
        end
        pkt_in_avail = 1'b0;
        chk("wrap_nrecv", 32'(nrecv), 32'd13);
        step();
        chk("wrap_end", 32'(put_outbound), 32'h0);

        // Reset during byte2
        pkt_in_avail = 1'b1;
        pkt_in       = 32'h5678_9ABC;
        step();
        pkt_in       = 32'h1357_2468;
        step();
        pkt_in_avail = 1'b0;
        chk("mr_b0", 32'(payload_outbound), 32'h56);
        step();
        step();
        chk("mr_b2", {23'd0, put_outbound, payload_outbound}, 32'h19A);
        reset_n = 1'b0;
        step();
        chk("mr_put",   32'(put_outbound),       32'h0);
        chk("mr_pay",   32'(payload_outbound),   32'h00);
        chk("mr_ready", 32'(ready_to_recv),      32'h1);
        chk("mr_count", 32'(dut.u_fifo.count_o), 32'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mr_quiet", 32'(put_outbound), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
